fetch_stall_flush_ctrl: RTL and testbench
=========================================

// Module: fetch_stall_flush_ctrl
// PURPOSE
// - Consumer side of the hazard-control interface. Applies the hazard unit's NoOp/Stall/PCWrite
//   decisions and the ID-stage branch flush to the front end.
// - Owns the PC register, the IF/ID pipeline register and the ID/EX control-field register.
// - Inserts bubbles and squashes fetched instructions.
// - Keeps saturating stall/flush event counters for debug.
// PARAMETERS
// - XLEN      32     PC/instruction width
// - RESET_PC  0      PC value after reset
// - CTRL_W    8      width of decoded control bundle carried into ID/EX
// - CNT_W     16     width of stall/flush counters
// PORTS
// - clk_i            in   1       clock; all state updates on rising edge
// - rst_i            in   1       asynchronous reset, active-high
// - start_i          in   1       run enable; 0 freezes all state (counters included)
// - stall_i          in   1       hazard unit Stall: hold PC and IF/ID
// - pcwrite_i        in   1       hazard unit PCWrite; 1 = PC may advance
// - noop_i           in   1       hazard unit NoOp: load ID/EX with a bubble
// - flush_i          in   1       branch taken in ID: squash IF/ID, redirect PC
// - branch_target_i  in   XLEN    redirect address, valid with flush_i
// - instr_i          in   XLEN    instruction memory read data for address pc_o (same cycle)
// - ctrl_i           in   CTRL_W  decoded control of instruction currently in ID
// - pc_o             out  XLEN    fetch PC
// - ifid_pc_o        out  XLEN    PC of instruction in ID
// - ifid_instr_o     out  XLEN    instruction in ID
// - ifid_valid_o     out  1       ID holds a real instruction
// - idex_ctrl_o      out  CTRL_W  control bundle in EX
// - idex_valid_o     out  1       EX holds a real instruction
// - stall_cnt_o      out  CNT_W   cycles with stall applied
// - flush_cnt_o      out  CNT_W   flushes applied
// BEHAVIOUR
// - Reset (async, immediate):
//   - pc_o=RESET_PC; ifid_pc_o=0; ifid_instr_o=NOP (32'h00000013); ifid_valid_o=0.
//   - idex_ctrl_o=0; idex_valid_o=0; counters=0.
// - Latency: 1 cycle per stage; no combinational path from any input to any output.
// - start_i=0: every register holds, including counters.
// - hold = stall_i | ~pcwrite_i (either polarity of request stops PC).
// - flush_eff = flush_i & ~stall_i.
//   - A flush during stall is ignored: the branch depends on the stalled load and is re-evaluated next cycle.
// - PC:
//   - hold -> keep.
//   - else flush_eff -> {branch_target_i[XLEN-1:2],2'b00}.
//   - else pc_o+4, modulo 2^XLEN (0xFFFFFFFC -> 0).
// - IF/ID:
//   - stall_i -> keep all three fields.
//   - else flush_eff -> ifid_instr_o=NOP, ifid_valid_o=0, ifid_pc_o=pc_o.
//   - else capture {pc_o, instr_i}, valid=1.
// - ID/EX:
//   - noop_i -> idex_ctrl_o=0, idex_valid_o=0 (regardless of stall_i).
//   - else idex_ctrl_o=ctrl_i, idex_valid_o=ifid_valid_o.
// - Combination stall_i=1, noop_i=0: ID/EX still loads ctrl_i (the duplicate is legal only because the
//   hazard unit always pairs them); no checking is performed.
// - Counters (saturate at all-ones, never wrap):
//   - stall_cnt_o +1 each start_i cycle with stall_i=1.
//   - flush_cnt_o +1 each cycle with flush_eff=1.
// - Reset mid-stall/flush: all pending effects are discarded; fetch restarts at RESET_PC on the first edge
//   after rst_i falls.
// STRUCTURE
// - Const.v gains:
//   - `NOP_INSTR 32'h00000013
//   - `RESET_PC default
//   - `PC_STEP 4
// - One sub-module: sat_counter (CNT_W, async active-high reset, enable, saturates); two instances.
// - PC, IF/ID and ID/EX are plain always blocks in the top.
// TESTING
// - Free run, start_i=1, no hazards, 4 cycles:
//   - pc_o 0,4,8,12.
//   - ifid_pc_o lags by 1.
//   - idex_valid_o first 1 at cycle 3.
// - Load-use: stall_i=noop_i=1, pcwrite_i=0 for 1 cycle at pc_o=8:
//   - pc_o stays 8.
//   - IF/ID unchanged.
//   - idex_ctrl_o=0, idex_valid_o=0.
//   - stall_cnt_o=1.
// - Branch: flush_i=1, target 0x103 at pc_o=0x20:
//   - next pc_o=0x100.
//   - ifid_instr_o=0x13, ifid_valid_o=0.
//   - flush_cnt_o=1.
// - stall_i=1 and flush_i=1 in the same cycle:
//   - PC held.
//   - flush_cnt_o unchanged.
//   - branch accepted the following cycle when stall_i=0.
// - PC wrap: force pc_o=0xFFFFFFFC -> next pc_o=0x0.
//   - Counter saturation: stall_i=1 for 70000 cycles -> stall_cnt_o=16'hFFFF.
// - Async reset asserted mid-stall, no clock edge:
//   - outputs reach reset values immediately.
//   - after release, pc_o=RESET_PC.

Source files
------------

// File: rtl/fetch_stall_flush_ctrl_pkg.sv
// Shared constants for the fetch stall/flush controller.
// Holds the canonical NOP encoding, the sequential PC increment and default widths.
package fetch_stall_flush_ctrl_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned CTRL_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_STEP      = 4;

endpackage

// File: rtl/fetch_stall_flush_ctrl_sat_counter.sv
// Saturating event counter: counts enabled cycles, sticks at all-ones.
// Ports: clk, rst (async, active-high), en (count this cycle), count (current value).
module sat_counter
  import fetch_stall_flush_ctrl_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_stall_flush_ctrl.sv
// Front-end hazard consumer: applies Stall/PCWrite/NoOp and the ID-stage branch
// flush to the PC, IF/ID and ID/EX control registers, and counts stall/flush events.
// Ports: clk_i, rst_i (async, active-high), start_i (run enable), stall_i, pcwrite_i,
//        noop_i, flush_i, branch_target_i, instr_i, ctrl_i;
//        outputs pc_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, idex_ctrl_o,
//        idex_valid_o, stall_cnt_o, flush_cnt_o (all registered).
module fetch_stall_flush_ctrl
  import fetch_stall_flush_ctrl_pkg::*;
#(
  parameter int unsigned       XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0]   RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int unsigned       CTRL_W   = CTRL_W_DEF,
  parameter int unsigned       CNT_W    = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              pcwrite_i,
  input  logic              noop_i,
  input  logic              flush_i,
  input  logic [XLEN-1:0]   branch_target_i,
  input  logic [XLEN-1:0]   instr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   ifid_pc_o,
  output logic [XLEN-1:0]   ifid_instr_o,
  output logic              ifid_valid_o,
  output logic [CTRL_W-1:0] idex_ctrl_o,
  output logic              idex_valid_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic            hold_c;
  logic            flush_eff_c;
  logic [XLEN-1:0] target_c;

  // A flush raised while stalled depends on the stalled load; it is dropped and
  // the hazard unit re-raises it once the stall clears.
  assign hold_c      = stall_i | ~pcwrite_i;
  assign flush_eff_c = flush_i & ~stall_i;
  assign target_c    = branch_target_i & ~XLEN'(3);

  // PC register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_o <= RESET_PC;
    end else if (start_i && !hold_c) begin
      if (flush_eff_c) pc_o <= target_c;
      else             pc_o <= pc_o + XLEN'(PC_STEP);
    end
  end

  // IF/ID register; a squashed slot keeps the fetch PC for debug visibility
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ifid_pc_o    <= '0;
      ifid_instr_o <= XLEN'(NOP_INSTR);
      ifid_valid_o <= 1'b0;
    end else if (start_i && !stall_i) begin
      ifid_pc_o <= pc_o;
      if (flush_eff_c) begin
        ifid_instr_o <= XLEN'(NOP_INSTR);
        ifid_valid_o <= 1'b0;
      end else begin
        ifid_instr_o <= instr_i;
        ifid_valid_o <= 1'b1;
      end
    end
  end

  // ID/EX control register; NoOp wins over stall to inject the bubble
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idex_ctrl_o  <= '0;
      idex_valid_o <= 1'b0;
    end else if (start_i) begin
      if (noop_i) begin
        idex_ctrl_o  <= '0;
        idex_valid_o <= 1'b0;
      end else begin
        idex_ctrl_o  <= ctrl_i;
        idex_valid_o <= ifid_valid_o;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .en    (start_i & stall_i),
    .count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .en    (start_i & flush_eff_c),
    .count (flush_cnt_o)
  );

endmodule

// File: tb/tb_fetch_stall_flush_ctrl.sv
// Directed bench for fetch_stall_flush_ctrl: reset, free run, load-use bubble,
// branch flush, stall+flush collision, PC wrap, start freeze, counter saturation
// and asynchronous reset.
module tb_fetch_stall_flush_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stall;
  logic        pcwrite;
  logic        noop;
  logic        flush;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic [7:0]  ctrl;
  logic [31:0] pc;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic [7:0]  idex_ctrl;
  logic        idex_valid;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  // Instruction memory model: content is a fixed function of the address
  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign instr = imem(pc);

  fetch_stall_flush_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .stall_i         (stall),
    .pcwrite_i       (pcwrite),
    .noop_i          (noop),
    .flush_i         (flush),
    .branch_target_i (branch_target),
    .instr_i         (instr),
    .ctrl_i          (ctrl),
    .pc_o            (pc),
    .ifid_pc_o       (ifid_pc),
    .ifid_instr_o    (ifid_instr),
    .ifid_valid_o    (ifid_valid),
    .idex_ctrl_o     (idex_ctrl),
    .idex_valid_o    (idex_valid),
    .stall_cnt_o     (stall_cnt),
    .flush_cnt_o     (flush_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hazard(input logic s, input logic n, input logic pw);
    stall = s; noop = n; pcwrite = pw;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; set_hazard(1'b0, 1'b0, 1'b1);
    flush = 1'b0; branch_target = '0; ctrl = 8'h5A;
    step(); step();
    rst = 1'b0;
    total++; if (pc !== 32'h0) $display("FAIL reset_pc got %h want %h", pc, 32'h0); else pass_cnt++;
    total++; if (ifid_pc !== 32'h0) $display("FAIL reset_ifid_pc got %h want %h", ifid_pc, 32'h0); else pass_cnt++;
    total++; if (ifid_instr !== 32'h13) $display("FAIL reset_ifid_instr got %h want %h", ifid_instr, 32'h13); else pass_cnt++;
    total++; if (ifid_valid !== 1'b0) $display("FAIL reset_ifid_valid got %b want 0", ifid_valid); else pass_cnt++;
    total++; if (idex_ctrl !== 8'h0 || idex_valid !== 1'b0) $display("FAIL reset_idex got %h/%b want 00/0", idex_ctrl, idex_valid); else pass_cnt++;
    total++; if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0) $display("FAIL reset_cnt got %h/%h want 0000/0000", stall_cnt, flush_cnt); else pass_cnt++;
  endtask

  task automatic test_free_run();
    start = 1'b1;
    step();
    total++; if (pc !== 32'h4) $display("FAIL run1_pc got %h want %h", pc, 32'h4); else pass_cnt++;
    total++; if (ifid_pc !== 32'h0 || ifid_valid !== 1'b1) $display("FAIL run1_ifid got %h/%b want 0/1", ifid_pc, ifid_valid); else pass_cnt++;
    total++; if (ifid_instr !== 32'hA5A5_0000) $display("FAIL run1_instr got %h want %h", ifid_instr, 32'hA5A5_0000); else pass_cnt++;
    total++; if (idex_valid !== 1'b0) $display("FAIL run1_idex_valid got %b want 0", idex_valid); else pass_cnt++;
    step();
    total++; if (pc !== 32'h8) $display("FAIL run2_pc got %h want %h", pc, 32'h8); else pass_cnt++;
    total++; if (ifid_pc !== 32'h4) $display("FAIL run2_ifid_pc got %h want %h", ifid_pc, 32'h4); else pass_cnt++;
    total++; if (idex_valid !== 1'b1 || idex_ctrl !== 8'h5A) $display("FAIL run2_idex got %h/%b want 5a/1", idex_ctrl, idex_valid); else pass_cnt++;
  endtask

  task automatic test_load_use();
    set_hazard(1'b1, 1'b1, 1'b0);
    step();
    set_hazard(1'b0, 1'b0, 1'b1);
    total++; if (pc !== 32'h8) $display("FAIL lu_pc got %h want %h", pc, 32'h8); else pass_cnt++;
    total++; if (ifid_pc !== 32'h4 || ifid_instr !== 32'hA5A5_0004 || ifid_valid !== 1'b1)
      $display("FAIL lu_ifid got %h/%h/%b want 4/a5a50004/1", ifid_pc, ifid_instr, ifid_valid); else pass_cnt++;
    total++; if (idex_ctrl !== 8'h0 || idex_valid !== 1'b0) $display("FAIL lu_idex got %h/%b want 00/0", idex_ctrl, idex_valid); else pass_cnt++;
    total++; if (stall_cnt !== 16'd1) $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt); else pass_cnt++;
  endtask

  task automatic test_branch();
    repeat (6) step();
    total++; if (pc !== 32'h20) $display("FAIL br_pre_pc got %h want %h", pc, 32'h20); else pass_cnt++;
    flush = 1'b1; branch_target = 32'h103;
    step();
    flush = 1'b0;
    total++; if (pc !== 32'h100) $display("FAIL br_pc got %h want %h", pc, 32'h100); else pass_cnt++;
    total++; if (ifid_instr !== 32'h13 || ifid_valid !== 1'b0) $display("FAIL br_ifid got %h/%b want 13/0", ifid_instr, ifid_valid); else pass_cnt++;
    total++; if (ifid_pc !== 32'h20) $display("FAIL br_ifid_pc got %h want %h", ifid_pc, 32'h20); else pass_cnt++;
    total++; if (flush_cnt !== 16'd1) $display("FAIL br_flush_cnt got %0d want 1", flush_cnt); else pass_cnt++;
  endtask

  task automatic test_stall_flush();
    set_hazard(1'b1, 1'b1, 1'b0);
    flush = 1'b1; branch_target = 32'h200;
    step();
    total++; if (pc !== 32'h100) $display("FAIL sf_pc got %h want %h", pc, 32'h100); else pass_cnt++;
    total++; if (flush_cnt !== 16'd1) $display("FAIL sf_flush_cnt got %0d want 1", flush_cnt); else pass_cnt++;
    total++; if (stall_cnt !== 16'd2) $display("FAIL sf_stall_cnt got %0d want 2", stall_cnt); else pass_cnt++;
    set_hazard(1'b0, 1'b0, 1'b1);
    step();
    flush = 1'b0;
    total++; if (pc !== 32'h200) $display("FAIL sf_retry_pc got %h want %h", pc, 32'h200); else pass_cnt++;
    total++; if (flush_cnt !== 16'd2) $display("FAIL sf_retry_cnt got %0d want 2", flush_cnt); else pass_cnt++;
  endtask

  task automatic test_pc_wrap();
    flush = 1'b1; branch_target = 32'hFFFF_FFFF;
    step();
    flush = 1'b0;
    total++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pre_pc got %h want %h", pc, 32'hFFFF_FFFC); else pass_cnt++;
    step();
    total++; if (pc !== 32'h0) $display("FAIL wrap_pc got %h want %h", pc, 32'h0); else pass_cnt++;
    total++; if (ifid_pc !== 32'hFFFF_FFFC || ifid_valid !== 1'b1) $display("FAIL wrap_ifid got %h/%b want fffffffc/1", ifid_pc, ifid_valid); else pass_cnt++;
  endtask

  task automatic test_start_freeze();
    start = 1'b0; stall = 1'b1; flush = 1'b1; branch_target = 32'h40;
    step(); step();
    total++; if (pc !== 32'h0 || stall_cnt !== 16'd2 || flush_cnt !== 16'd3)
      $display("FAIL freeze got pc %h cnt %0d/%0d want 0 2/3", pc, stall_cnt, flush_cnt); else pass_cnt++;
    start = 1'b1; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_saturation();
    step(); step();
    total++; if (pc !== 32'h8) $display("FAIL sat_pre_pc got %h want %h", pc, 32'h8); else pass_cnt++;
    set_hazard(1'b1, 1'b1, 1'b0);
    repeat (65533) step();
    total++; if (stall_cnt !== 16'hFFFF) $display("FAIL sat_reach got %h want ffff", stall_cnt); else pass_cnt++;
    repeat (4467) step();
    total++; if (stall_cnt !== 16'hFFFF) $display("FAIL sat_hold got %h want ffff", stall_cnt); else pass_cnt++;
    total++; if (pc !== 32'h8) $display("FAIL sat_pc got %h want %h", pc, 32'h8); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    total++; if (pc !== 32'h0 || ifid_valid !== 1'b0 || ifid_instr !== 32'h13)
      $display("FAIL arst_front got %h/%b/%h want 0/0/13", pc, ifid_valid, ifid_instr); else pass_cnt++;
    total++; if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0 || idex_valid !== 1'b0)
      $display("FAIL arst_back got %h/%h/%b want 0/0/0", stall_cnt, flush_cnt, idex_valid); else pass_cnt++;
    set_hazard(1'b0, 1'b0, 1'b1);
    #1;
    rst = 1'b0;
    total++; if (pc !== 32'h0) $display("FAIL arst_rel_pc got %h want %h", pc, 32'h0); else pass_cnt++;
    step();
    total++; if (pc !== 32'h4 || ifid_pc !== 32'h0 || ifid_valid !== 1'b1)
      $display("FAIL arst_restart got %h/%h/%b want 4/0/1", pc, ifid_pc, ifid_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_load_use();
    test_branch();
    test_stall_flush();
    test_pc_wrap();
    test_start_freeze();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
